// File: rtl/seven_segment_loop_monitor.sv
// Receive-side checker for a one-hot rotating 7-segment bus: decodes the lit segment,
// locks onto the 0..6 rotation, and reports skips, glitches and stalls.
module seven_segment_loop_monitor #(
  parameter int unsigned LOCK_STEPS  = 3,
  parameter int unsigned STALL_LIMIT = 16,
  parameter int unsigned LOOP_W      = 8,
  parameter int unsigned ERR_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        segments_in,
  output logic [2:0]        position,
  output logic              position_valid,
  output logic              locked,
  output logic              seq_error,
  output logic              stalled,
  output logic [LOOP_W-1:0] loop_count,
  output logic [ERR_W-1:0]  error_count
);

  localparam int unsigned RunW = (LOCK_STEPS > 1) ? $clog2(LOCK_STEPS) : 1;
  localparam logic [RunW-1:0] LockLast = RunW'(LOCK_STEPS - 1);
  // hold_q counts repeats, so the STALL_LIMIT-th identical sample sees STALL_LIMIT-2
  localparam logic [7:0] HoldStall = 8'(STALL_LIMIT - 2);
  localparam logic [7:0] HoldMax   = 8'(STALL_LIMIT);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;
  typedef enum logic [1:0] {StepNone, StepAdvance, StepHold, StepBad} step_e;

  state_e          state_q;
  logic [RunW-1:0] run_q;
  logic [7:0]      hold_q;
  logic [2:0]      prev_pos_q;
  logic            prev_valid_q;

  logic       onehot;
  logic [2:0] cur;
  logic [2:0] next_pos;
  logic       wrap;
  step_e      step;

  always_comb begin
    onehot = (segments_in != 7'd0) && ((segments_in & (segments_in - 7'd1)) == 7'd0);
    cur    = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (segments_in[i]) cur = 3'(i);
    end
  end

  always_comb begin
    next_pos = (prev_pos_q == 3'd6) ? 3'd0 : prev_pos_q + 3'd1;
    wrap     = (prev_pos_q == 3'd6);
    step     = StepNone;
    if (prev_valid_q) begin
      if (!onehot)               step = StepBad;
      else if (cur == next_pos)  step = StepAdvance;
      else if (cur == prev_pos_q) step = StepHold;
      else                       step = StepBad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StHunt;
      run_q          <= '0;
      hold_q         <= '0;
      prev_pos_q     <= '0;
      prev_valid_q   <= 1'b0;
      position       <= '0;
      position_valid <= 1'b0;
      locked         <= 1'b0;
      seq_error      <= 1'b0;
      stalled        <= 1'b0;
      loop_count     <= '0;
      error_count    <= '0;
    end else begin
      seq_error      <= 1'b0;
      position_valid <= onehot;
      prev_valid_q   <= onehot;
      if (onehot) begin
        position   <= cur;
        prev_pos_q <= cur;
      end

      if (step == StepHold) begin
        if (hold_q != HoldMax) hold_q <= hold_q + 8'd1;
      end else begin
        hold_q <= '0;
      end

      if (step == StepAdvance) stalled <= 1'b0;

      unique case (state_q)
        StHunt: begin
          case (step)
            StepAdvance: begin
              if (run_q == LockLast) begin
                state_q <= StLocked;
                locked  <= 1'b1;
                run_q   <= '0;
              end else begin
                run_q <= run_q + 1'b1;
              end
            end
            StepBad: run_q <= '0;
            default: ;
          endcase
        end
        StLocked: begin
          if (step == StepAdvance && wrap) loop_count <= loop_count + 1'b1;
          if (step == StepBad || (step == StepHold && hold_q == HoldStall)) begin
            seq_error <= 1'b1;
            if (step == StepHold) stalled <= 1'b1;
            if (error_count != '1) error_count <= error_count + 1'b1;
            state_q <= StHunt;
            locked  <= 1'b0;
            run_q   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_segment_loop_monitor.sv
// Directed bench for seven_segment_loop_monitor: a reference model pushes expected outputs
// to a queue per sample, popped and compared one cycle later on two parameterisations.
module tb_seven_segment_loop_monitor;

  localparam int LockSteps  = 3;
  localparam int StallLimit = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] segments_in = 7'd0;

  logic [2:0] position, position2;
  logic       position_valid, position_valid2;
  logic       locked, locked2;
  logic       seq_error, seq_error2;
  logic       stalled, stalled2;
  logic [7:0] loop_count;
  logic [1:0] loop_count2;
  logic [7:0] error_count;
  logic [1:0] error_count2;

  seven_segment_loop_monitor u_dut (
    .clk            (clk),
    .rst            (rst),
    .segments_in    (segments_in),
    .position       (position),
    .position_valid (position_valid),
    .locked         (locked),
    .seq_error      (seq_error),
    .stalled        (stalled),
    .loop_count     (loop_count),
    .error_count    (error_count)
  );

  seven_segment_loop_monitor #(
    .LOOP_W (2),
    .ERR_W  (2)
  ) u_dut2 (
    .clk            (clk),
    .rst            (rst),
    .segments_in    (segments_in),
    .position       (position2),
    .position_valid (position_valid2),
    .locked         (locked2),
    .seq_error      (seq_error2),
    .stalled        (stalled2),
    .loop_count     (loop_count2),
    .error_count    (error_count2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] pos;
    logic       pv;
    logic       lk;
    logic       se;
    logic       st;
    int         loops;
    int         errs;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_locked;
  int m_run, m_same, m_prev, m_pos, m_loops, m_errs;
  bit m_pv, m_se, m_st;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [6:0] seg, input logic r);
    int idx;
    bit v;
    int kind;  // 0 unclassified, 1 advance, 2 hold, 3 bad
    if (r) begin
      m_locked = 0; m_run = 0; m_same = 0; m_prev = -1; m_pos = 0;
      m_pv = 0; m_se = 0; m_st = 0; m_loops = 0; m_errs = 0;
      return;
    end
    v   = ($countones(seg) == 1);
    idx = -1;
    for (int i = 0; i < 7; i++) if (seg[i] && v) idx = i;
    m_se = 0;
    kind = 0;
    if (m_prev >= 0) begin
      if (!v)                          kind = 3;
      else if (idx == (m_prev + 1) % 7) kind = 1;
      else if (idx == m_prev)           kind = 2;
      else                              kind = 3;
    end
    m_same = (kind == 2) ? m_same + 1 : 1;
    if (kind == 1) m_st = 0;
    if (!m_locked) begin
      if (kind == 1) begin
        m_run++;
        if (m_run == LockSteps) begin
          m_locked = 1;
          m_run = 0;
        end
      end else if (kind == 3) begin
        m_run = 0;
      end
    end else begin
      if (kind == 1 && idx == 0) m_loops++;
      if ((kind == 2 && m_same == StallLimit) || kind == 3) begin
        m_se = 1;
        m_errs++;
        m_locked = 0;
        m_run = 0;
        if (kind == 2) m_st = 1;
      end
    end
    m_pv = v;
    if (v) m_pos = idx;
    m_prev = v ? idx : -1;
  endtask

  task automatic check_outputs();
    exp_t e;
    if (q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = q.pop_front();
    chk("position",        position,        e.pos);
    chk("position_valid",  position_valid,  e.pv);
    chk("locked",          locked,          e.lk);
    chk("seq_error",       seq_error,       e.se);
    chk("stalled",         stalled,         e.st);
    chk("loop_count",      loop_count,      e.loops % 256);
    chk("error_count",     error_count,     (e.errs > 255) ? 255 : e.errs);
    chk("w2_locked",       locked2,         e.lk);
    chk("w2_seq_error",    seq_error2,      e.se);
    chk("w2_loop_count",   loop_count2,     e.loops % 4);
    chk("w2_error_count",  error_count2,    (e.errs > 3) ? 3 : e.errs);
  endtask

  task automatic drive(input logic [6:0] seg, input logic r);
    exp_t e;
    segments_in = seg;
    rst = r;
    model(seg, r);
    e.pos = 3'(m_pos); e.pv = m_pv; e.lk = m_locked; e.se = m_se; e.st = m_st;
    e.loops = m_loops; e.errs = m_errs;
    q.push_back(e);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic put(input int p);
    logic [6:0] s;
    s = 7'd1 << p;
    drive(s, 1'b0);
  endtask

  task automatic do_reset();
    drive(7'd0, 1'b1);
    rst = 1'b0;
  endtask

  int exp_l2[5] = '{1, 2, 3, 0, 1};

  initial begin
    // Reset state
    do_reset();
    chk("rst_locked", locked, 0);
    chk("rst_loops", loop_count, 0);

    // Lock-on and three full loops
    put(0); put(1); put(2);
    chk("t1_not_yet_locked", locked, 0);
    put(3);
    chk("t1_locked_after_3", locked, 1);
    put(4); put(5); put(6); put(0);
    chk("t1_first_loop", loop_count, 1);
    for (int l = 0; l < 2; l++) begin
      for (int p = 1; p < 7; p++) put(p);
      put(0);
    end
    chk("t1_three_loops", loop_count, 3);
    chk("t1_no_errors", error_count, 0);

    // Blank glitch while locked
    put(1); put(2);
    drive(7'd0, 1'b0);
    chk("t2_seq_error", seq_error, 1);
    chk("t2_err_count", error_count, 1);
    chk("t2_unlocked", locked, 0);
    put(3); put(4); put(5);
    chk("t2_not_relocked", locked, 0);
    put(6);
    chk("t2_relocked", locked, 1);
    put(0);
    chk("t2_loop4", loop_count, 4);

    // Skipped step
    put(1); put(2); put(4);
    chk("t3_seq_error", seq_error, 1);
    chk("t3_unlocked", locked, 0);
    chk("t3_position", position, 4);
    chk("t3_pos_valid", position_valid, 1);

    // Lock-entry on a 6->0 wrap does not count a loop
    put(5); put(6); put(0);
    chk("t3_relocked", locked, 1);
    chk("t3_no_wrap_count", loop_count, 4);
    put(1);

    // Stall: sixteen identical samples, first one being the advance into 2
    for (int i = 0; i < StallLimit - 1; i++) put(2);
    chk("t4_no_early_stall", stalled, 0);
    chk("t4_still_locked", locked, 1);
    put(2);
    chk("t4_stall_pulse", seq_error, 1);
    chk("t4_stalled", stalled, 1);
    chk("t4_unlocked", locked, 0);
    chk("t4_err_count", error_count, 3);
    put(3);
    chk("t4_stall_cleared", stalled, 0);
    chk("t4_hunt", locked, 0);

    // Two-hot pattern in HUNT
    drive(7'b0000011, 1'b0);
    chk("t5_pos_valid", position_valid, 0);
    chk("t5_pos_kept", position, 3);
    chk("t5_no_seq_error", seq_error, 0);
    chk("t5_err_unchanged", error_count, 3);

    // Narrow loop counter wraps
    put(4); put(5); put(6); put(0);
    chk("t6_locked", locked, 1);
    for (int l = 0; l < 5; l++) begin
      for (int p = 1; p < 7; p++) put(p);
      put(0);
      chk("t6_w2_loop_seq", loop_count2, exp_l2[l]);
    end

    // Reset mid-loop, then relock from scratch
    put(1); put(2); put(3);
    do_reset();
    chk("t7_loops_zero", loop_count, 0);
    chk("t7_errs_zero", error_count, 0);
    chk("t7_unlocked", locked, 0);
    put(0); put(1); put(2); put(3);
    chk("t7_relocked", locked, 1);

    // Stall coinciding with reset: reset wins
    for (int i = 0; i < StallLimit - 2; i++) put(3);
    drive(7'b0001000, 1'b1);
    rst = 1'b0;
    chk("t8_no_pulse", seq_error, 0);
    chk("t8_not_stalled", stalled, 0);
    chk("t8_errs_zero", error_count, 0);
    put(3);

    // Error count saturation on the narrow instance
    for (int k = 0; k < 5; k++) begin
      put(0); put(1); put(2); put(3);
      drive(7'd0, 1'b0);
      chk("t9_pulse", seq_error, 1);
      chk("t9_w2_pulse", seq_error2, 1);
    end
    chk("t9_err_count", error_count, 5);
    chk("t9_w2_saturated", error_count2, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
